// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
//   Time-multiplexed FIR controller. A single multiply-accumulate is stepped over
//   TAPS coefficients for every accepted sample. The block keeps the delay line
//   x[n]..x[n-TAPS+1] and emits one filtered word per sample.
//
//   Coefficients live in two banks:
//     - shadow: written at any time through the cfg_* port
//     - active: a copy of shadow taken at each sample accept
//   A sample in flight therefore never sees a coefficient change.
//
//   Optional feature (compile-time macro FIR_SEQ_SAT_EN):
//     defined   -> samples are signed, the accumulator keeps full precision
//                  (N+CW+TW bits) and data_out saturates to the signed N-bit range
//     undefined -> products and accumulator wrap modulo 2^N
//
// Ports
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous, active-low
//   in_valid   in   1     data_in holds a sample
//   in_ready   out  1     block can take a sample this cycle (IDLE only)
//   data_in    in   N     input sample
//   out_valid  out  1     data_out holds a result (OUT state)
//   out_ready  in   1     sink takes data_out this cycle
//   data_out   out  N     filter result
//   cfg_we     in   1     coefficient write strobe
//   cfg_addr   in   TW    tap index to write (>= TAPS is ignored)
//   cfg_data   in   CW    signed coefficient value
//   busy       out  1     high in every state except IDLE
// -----------------------------------------------------------------------------
module fir_mac_sequencer #(
  parameter int N    = 16,
  parameter int TAPS = 4,
  parameter int CW   = 6,
  localparam int TW  = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [N-1:0]  data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic        [N-1:0]  data_out,
  input  logic                 cfg_we,
  input  logic        [TW-1:0] cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [N-1:0]  x_q  [TAPS];
  logic signed [CW-1:0] ca_q [TAPS];
  logic signed [CW-1:0] cs_q [TAPS];
  logic        [TW-1:0] idx_q;
  logic        [N-1:0]  dout_q;

  logic                 accept;
  logic                 last_tap;
  logic signed [N-1:0]  x_sel;
  logic signed [CW-1:0] c_sel;
  logic [(1<<TW)-1:0]   tap_ok;

  // Power-on / reset coefficient set; taps beyond the fourth start at zero.
  function automatic logic signed [CW-1:0] def_coef(input int i);
    int v;
    v = 0;
    case (i)
      0:       v = 13;
      1:       v = -16;
      2:       v = 19;
      3:       v = -21;
      default: v = 0;
    endcase
    return CW'(v);
  endfunction

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign last_tap = (idx_q == TW'(TAPS - 1));
  assign x_sel    = x_q[idx_q];
  assign c_sel    = ca_q[idx_q];

  // Address decode that stays valid when TAPS is not a power of two.
  always_comb begin
    for (int i = 0; i < (1 << TW); i++) begin
      tap_ok[i] = (i < TAPS);
    end
  end

`ifdef FIR_SEQ_SAT_EN
  localparam int AW = N + CW + TW;

  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [N+CW-1:0] prod;

  // Clamp the full-precision sum into the signed N-bit output range.
  function automatic logic [N-1:0] acc_word(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] maxv;
    logic signed [AW-1:0] minv;
    maxv = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
    minv = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
    if (a > maxv)      return {1'b0, {(N-1){1'b1}}};
    else if (a < minv) return {1'b1, {(N-1){1'b0}}};
    else               return a[N-1:0];
  endfunction

  always_comb begin
    prod  = (N+CW)'(x_sel) * (N+CW)'(c_sel);
    acc_d = acc_q + AW'(prod);
  end
`else
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] prod;
  logic [N-1:0] c_ext;

  // Plain modulo-2^N result: the accumulator already is the output word.
  function automatic logic [N-1:0] acc_word(input logic [N-1:0] a);
    return a;
  endfunction

  always_comb begin
    c_ext = {{(N-CW){c_sel[CW-1]}}, c_sel};
    prod  = x_sel * c_ext;
    acc_d = acc_q + prod;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_MAC;
      S_MAC:   if (last_tap)  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Delay line, coefficient banks and MAC datapath.
  // The shadow write and the shadow->active copy share an edge on purpose:
  // the copy reads the old shadow, so a coincident write applies to the next sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]  <= '0;
        ca_q[k] <= def_coef(k);
        cs_q[k] <= def_coef(k);
      end
      acc_q  <= '0;
      idx_q  <= '0;
      dout_q <= '0;
    end else begin
      if (cfg_we && tap_ok[cfg_addr]) begin
        cs_q[cfg_addr] <= cfg_data;
      end
      if (accept) begin
        x_q[0] <= data_in;
        for (int k = 1; k < TAPS; k++) begin
          x_q[k] <= x_q[k-1];
        end
        ca_q  <= cs_q;
        acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == S_MAC) begin
        acc_q <= acc_d;
        idx_q <= last_tap ? '0 : idx_q + TW'(1);
        if (last_tap) begin
          dout_q <= acc_word(acc_d);
        end
      end
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

  localparam int N    = 16;
  localparam int TAPS = 4;
  localparam int CW   = 6;
  localparam int TW   = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [N-1:0]  data_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic        [N-1:0]  data_out;
  logic                 cfg_we = 1'b0;
  logic        [TW-1:0] cfg_addr = '0;
  logic signed [CW-1:0] cfg_data = '0;
  logic                 busy;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.N(N), .TAPS(TAPS), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .busy      (busy)
  );

  typedef struct {
    logic [N-1:0] din;
    logic [N-1:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic cfg_write(input logic [TW-1:0] a, input logic signed [CW-1:0] v);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = v;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Waits (bounded) for out_valid and returns data_out; does not complete the handshake.
  task automatic wait_result(output logic [N-1:0] r);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) check("tmo_out_valid", {31'd0, out_valid}, 32'd1);
    r = data_out;
  endtask

  task automatic send(input logic [N-1:0] d, output logic [N-1:0] r);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) check("tmo_in_ready", {31'd0, in_ready}, 32'd1);
    data_in  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(r);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] sat_exp;

    // Reset state, sampled while reset is held low
    reset = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_data_out",  {16'd0, data_out},  32'd0);
    reset = 1'b1;
    tick();

    // Impulse then step, default coefficients {13,-16,19,-21}
    tbl.push_back('{16'd1, 16'h000D});
    tbl.push_back('{16'd0, 16'hFFF0});
    tbl.push_back('{16'd0, 16'h0013});
    tbl.push_back('{16'd0, 16'hFFEB});
    tbl.push_back('{16'd0, 16'h0000});
    tbl.push_back('{16'd1, 16'h000D});
    tbl.push_back('{16'd1, 16'hFFFD});
    tbl.push_back('{16'd1, 16'h0010});
    tbl.push_back('{16'd1, 16'hFFFB});
    tbl.push_back('{16'd1, 16'hFFFB});
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].din, r);
      check($sformatf("vec%0d", i), {16'd0, r}, {16'd0, tbl[i].exp});
    end

    // Backpressure: result 2*13 held for 10 cycles, a second sample waits upstream
    do_reset();
    out_ready = 1'b0;
    data_in   = 16'd2;
    in_valid  = 1'b1;
    tick();
    data_in   = 16'd3;
    wait_result(r);
    check("bp_first", {16'd0, r}, 32'h001A);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", {13'd0, out_valid, in_ready, busy, data_out}, {13'd0, 1'b1, 1'b0, 1'b1, 16'h001A});
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);
    tick();
    in_valid = 1'b0;
    wait_result(r);
    check("bp_next", {16'd0, r}, 32'h0007);
    tick();

    // Coefficient loading
    do_reset();
    cfg_write(2'd0, 6'sd1);
    cfg_write(2'd1, 6'sd0);
    cfg_write(2'd2, 6'sd0);
    cfg_write(2'd3, 6'sd0);
    send(16'd5, r);
    check("cfg_pass5", {16'd0, r}, 32'h0005);
    send(16'd7, r);
    check("cfg_pass7", {16'd0, r}, 32'h0007);
    // write during MAC: only the following sample sees tap1=2
    data_in  = 16'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_write(2'd1, 6'sd2);
    wait_result(r);
    check("cfg_inflight", {16'd0, r}, 32'h0009);
    tick();
    send(16'd4, r);
    check("cfg_next", {16'd0, r}, 32'h0016);
    // back-to-back writes to tap0: the second one wins
    cfg_write(2'd0, 6'sd3);
    cfg_write(2'd0, 6'sd6);
    // write coincident with accept applies from the next sample
    data_in  = 16'd1;
    in_valid = 1'b1;
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = -6'sd1;
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    wait_result(r);
    check("cfg_lastwins", {16'd0, r}, 32'h000E);
    tick();
    send(16'd0, r);
    check("cfg_coincident", {16'd0, r}, 32'h0002);

    // Large input: saturates or wraps depending on the build
`ifdef FIR_SEQ_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h7FF3;
`endif
    do_reset();
    send(16'h7FFF, r);
    check("sat_7fff", {16'd0, r}, {16'd0, sat_exp});

    // Reset in the middle of MAC discards the sample and restores coefficients
    do_reset();
    cfg_write(2'd0, 6'sd5);
    data_in  = 16'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mac_flags", {29'd0, busy, in_ready, out_valid}, 32'b100);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid", {13'd0, out_valid, busy, in_ready, data_out}, {13'd0, 1'b0, 1'b0, 1'b1, 16'h0000});
    tick();
    reset = 1'b1;
    tick();
    send(16'd1, r);
    check("rst_impulse", {16'd0, r}, 32'h000D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
